// File: rtl/button_mem_pkg.sv
// Shared types and helpers for the dual-port button memory.
// Byte-lane merge and clear-sequencer state encoding live here.
package button_mem_pkg;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Selects the new byte where its lane is enabled, otherwise keeps the old one.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/button_mem_rd_pipe.sv
// Read-return pipeline for one port: valid tracking plus an optional output register.
// With clken low every stage holds and readdatavalid is masked.
module button_mem_rd_pipe
    import button_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              rd_acc,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    localparam int LAT = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;

    logic v1_q, v1_d;

    always_comb begin
        v1_d = clken ? rd_acc : v1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
        end
    end

    generate
        if (LAT == READ_LAT_MAX) begin : g_outreg
            logic              v2_q, v2_d;
            logic [DATA_W-1:0] d2_q, d2_d;

            // Output register only reloads when a RAM result is arriving, so data holds otherwise.
            always_comb begin
                v2_d = v2_q;
                d2_d = d2_q;
                if (clken) begin
                    v2_d = v1_q;
                    if (v1_q) begin
                        d2_d = ram_q;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v2_d;
                    d2_q <= d2_d;
                end
            end

            assign readdata      = d2_q;
            assign readdatavalid = v2_q & clken;
        end else begin : g_direct
            assign readdata      = ram_q;
            assign readdatavalid = v1_q & clken;
        end
    endgenerate

endmodule

// File: rtl/button_onchip_memory_dp.sv
// Dual-port on-chip RAM shared by software (s1) and button-scan logic (s2),
// with optional zero-fill after reset driven through port A.
module button_onchip_memory_dp
    import button_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam clr_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clken && state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        busy           = (state_q == CLEAR);
        s1_waitrequest = busy | ~clken;
        s2_waitrequest = busy | ~clken;
        clr_we         = busy & clken;
    end

    // A simultaneous read+write on one port is treated as a write only.
    logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
    assign s1_wr_acc = s1_chipselect & s1_write & ~s1_waitrequest;
    assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
    assign s2_wr_acc = s2_chipselect & s2_write & ~s2_waitrequest;
    assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

    logic              collision;
    logic [DATA_W-1:0] coll_wd;
    assign collision = s1_wr_acc & s2_wr_acc & (s1_address == s2_address);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign coll_wd[gi*8 +: 8] = be_merge(s2_writedata[gi*8 +: 8],
                                                 s1_writedata[gi*8 +: 8],
                                                 s1_byteenable[gi]);
        end
    endgenerate

    // On a same-address collision port A carries the merged word and port B stays quiet.
    logic [ADDR_W-1:0] a_addr;
    logic              a_we, b_we;
    logic [NB-1:0]     a_be;
    logic [DATA_W-1:0] a_wd;

    always_comb begin
        a_addr = s1_address;
        a_we   = s1_wr_acc;
        a_be   = s1_byteenable;
        a_wd   = s1_writedata;
        b_we   = s2_wr_acc;
        if (clr_we) begin
            a_addr = clr_addr_q;
            a_we   = 1'b1;
            a_be   = '1;
            a_wd   = '0;
        end else if (collision) begin
            a_be = s1_byteenable | s2_byteenable;
            a_wd = coll_wd;
            b_we = 1'b0;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (a_we && a_be[b]) begin
                mem[a_addr][b*8 +: 8] <= a_wd[b*8 +: 8];
            end
            if (b_we && s2_byteenable[b]) begin
                mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
            end
        end
    end

    // Registered reads see the pre-write contents of the same edge.
    logic [DATA_W-1:0] ram1_q, ram2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram1_q <= '0;
            ram2_q <= '0;
        end else begin
            if (s1_rd_acc) begin
                ram1_q <= mem[s1_address];
            end
            if (s2_rd_acc) begin
                ram2_q <= mem[s2_address];
            end
        end
    end

    button_mem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe_s1 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .rd_acc        (s1_rd_acc),
        .ram_q         (ram1_q),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    button_mem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe_s2 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .rd_acc        (s2_rd_acc),
        .ram_q         (ram2_q),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule
